// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_pkg
// Purpose  : Shared types and helpers for the branch-resolution controller.
// Revision : 1.0  initial release
// ============================================================================
package bp_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } bp_upd_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bp_state_e;

  // A taken branch with the right direction can still mispredict on target.
  function automatic logic bp_is_mispred(input logic        taken,
                                         input logic        pred_taken,
                                         input logic [31:0] target,
                                         input logic [31:0] pred_target);
    return (taken != pred_taken) | (taken & pred_taken & (target != pred_target));
  endfunction

  function automatic logic [31:0] bp_correct_pc(input logic        taken,
                                                input logic [31:0] pc,
                                                input logic [31:0] target);
    return taken ? target : (pc + PC_STEP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_update_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_ctrl_if
// Purpose  : EX-side, fetch-redirect and predictor-update signals of the
//            branch-resolution controller.
// Revision : 1.0  initial release
// ============================================================================
interface bp_update_ctrl_if;

  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_taken;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_stall;

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;

  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;

  logic [31:0] perf_branches;
  logic [31:0] perf_mispred;

  modport slave (
    input  ex_valid, ex_pc, ex_target, ex_taken, ex_pred_taken, ex_pred_target,
    input  upd_ready,
    output ex_stall, redirect_valid, redirect_pc, flush,
    output upd_valid, upd_pc, upd_target, upd_taken,
    output perf_branches, perf_mispred
  );

  modport master (
    output ex_valid, ex_pc, ex_target, ex_taken, ex_pred_taken, ex_pred_target,
    output upd_ready,
    input  ex_stall, redirect_valid, redirect_pc, flush,
    input  upd_valid, upd_pc, upd_target, upd_taken,
    input  perf_branches, perf_mispred
  );

endinterface
`default_nettype wire

// File: rtl/bp_upd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bp_upd_fifo
// Purpose  : Synchronous FIFO of predictor training updates with push/pop,
//            full/empty/count and a head output driven from registered storage.
// Revision : 1.0  initial release
// ============================================================================
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  bp_upd_t                  data_i,
  input  logic                     pop_i,
  output bp_upd_t                  head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  bp_upd_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q,  count_d;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A full queue refuses the push even when the head leaves in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i  & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Gated so stale storage never reaches the predictor when empty.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/bp_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_ctrl
// Purpose  : Resolves EX branches against their prediction, redirects fetch
//            and times a flush on a mispredict, and queues predictor updates.
//            Optional BP_PERF_CNT_EN adds saturating branch/mispredict counters.
// Revision : 1.0  initial release
// ============================================================================
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int QDEPTH       = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  bp_update_ctrl_if.slave   bus
);

  localparam int              CW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int              CNT_W    = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(FLUSH_CYCLES - 1);
  localparam logic [0:0]      ST_RUN   = RUN;
  localparam logic [0:0]      ST_FLUSH = FLUSH;

  logic [0:0]       state_q,       state_d;
  logic [CW-1:0]    cnt_q,         cnt_d;
  logic             redir_valid_q, redir_valid_d;
  logic [31:0]      redir_pc_q,    redir_pc_d;

  logic             accept;
  logic             mispred;
  logic [31:0]      correct_pc;
  bp_upd_t          push_data;
  bp_upd_t          head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign mispred    = bp_is_mispred(bus.ex_taken, bus.ex_pred_taken,
                                    bus.ex_target, bus.ex_pred_target);
  assign correct_pc = bp_correct_pc(bus.ex_taken, bus.ex_pc, bus.ex_target);

  // Branches arriving during FLUSH are wrong-path and are dropped.
  assign accept = bus.ex_valid & ~fifo_full & (state_q == ST_RUN);

  assign push_data = '{pc: bus.ex_pc, target: bus.ex_target, taken: bus.ex_taken};

  bp_upd_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (accept),
    .data_i  (push_data),
    .pop_i   (bus.upd_ready),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    case (state_q)
      ST_RUN: begin
        if (accept && mispred) begin
          state_d       = ST_FLUSH;
          cnt_d         = CNT_INIT;
          redir_valid_d = 1'b1;
          redir_pc_d    = correct_pc;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign bus.ex_stall       = (fifo_count == CNT_W'(QDEPTH));
  assign bus.redirect_valid = redir_valid_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.flush          = (state_q == ST_FLUSH);

  assign bus.upd_valid  = ~fifo_empty;
  assign bus.upd_pc     = head.pc;
  assign bus.upd_target = head.target;
  assign bus.upd_taken  = head.taken;

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_br_q;
  logic [31:0] perf_mp_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (accept && (perf_br_q != '1))            perf_br_q <= perf_br_q + 32'd1;
      if (accept && mispred && (perf_mp_q != '1)) perf_mp_q <= perf_mp_q + 32'd1;
    end
  end

  assign bus.perf_branches = perf_br_q;
  assign bus.perf_mispred  = perf_mp_q;
`else
  assign bus.perf_branches = '0;
  assign bus.perf_mispred  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_update_ctrl
// Purpose  : Directed self-checking bench for bp_update_ctrl with an update
//            scoreboard; follows BP_PERF_CNT_EN for the counter expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_bp_update_ctrl;
  import bp_pkg::*;

  localparam int QD = 4;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int   exp_br;
  int   exp_mp;

  bp_upd_t sb [$];
  bp_upd_t exp_entry;
  bp_upd_t mon_e;
  logic    exp_acc;

  bp_update_ctrl_if bus ();

  bp_update_ctrl #(
    .QDEPTH       (QD),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle branch presentation; acc/mp are the bench's own expectations.
  task automatic drive(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic ptk, input logic [31:0] ptgt,
                       input logic acc, input logic mp);
    bus.ex_valid       = 1'b1;
    bus.ex_pc          = pc;
    bus.ex_target      = tgt;
    bus.ex_taken       = tk;
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptgt;
    exp_entry          = '{pc: pc, target: tgt, taken: tk};
    exp_acc            = acc;
    if (acc) begin
      exp_br++;
      if (mp) exp_mp++;
    end
    step();
    bus.ex_valid = 1'b0;
    exp_acc      = 1'b0;
  endtask

  task automatic chk_perf(input string tag);
`ifdef BP_PERF_CNT_EN
    chk({tag, "_perf_br"}, bus.perf_branches, exp_br);
    chk({tag, "_perf_mp"}, bus.perf_mispred,  exp_mp);
`else
    chk({tag, "_perf_br"}, bus.perf_branches, 32'd0);
    chk({tag, "_perf_mp"}, bus.perf_mispred,  32'd0);
`endif
  endtask

  // Scoreboard: compares the queue head on each handshake, then records pushes.
  always @(negedge clk) begin
    if (rstn) begin
      chk("mon_upd_valid", bus.upd_valid, (sb.size() != 0));
      chk("mon_ex_stall",  bus.ex_stall,  (sb.size() == QD));
      if (bus.upd_valid && bus.upd_ready && (sb.size() != 0)) begin
        mon_e = sb.pop_front();
        chk("mon_upd_pc",     bus.upd_pc,     mon_e.pc);
        chk("mon_upd_target", bus.upd_target, mon_e.target);
        chk("mon_upd_taken",  bus.upd_taken,  mon_e.taken);
      end
      if (exp_acc) sb.push_back(exp_entry);
    end
  end

  initial begin
    checks = 0; errors = 0; exp_br = 0; exp_mp = 0;
    exp_acc = 1'b0; exp_entry = '0;
    rstn = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_pc = '0; bus.ex_target = '0;
    bus.ex_taken = 1'b0; bus.ex_pred_taken = 1'b0; bus.ex_pred_target = '0;
    bus.upd_ready = 1'b0;

    // Reset state
    step();
    chk("rst_redirect_valid", bus.redirect_valid, 0);
    chk("rst_redirect_pc",    bus.redirect_pc,    0);
    chk("rst_flush",          bus.flush,          0);
    chk("rst_upd_valid",      bus.upd_valid,      0);
    chk("rst_upd_pc",         bus.upd_pc,         0);
    chk("rst_upd_target",     bus.upd_target,     0);
    chk("rst_upd_taken",      bus.upd_taken,      0);
    chk("rst_ex_stall",       bus.ex_stall,       0);
    chk_perf("rst");
    rstn = 1'b1;
    step();

    // Mid-run async reset with three queued updates and a flush in flight
    drive(32'h10, 32'h20, 1'b1, 1'b1, 32'h20, 1'b1, 1'b0);
    drive(32'h30, 32'h50, 1'b0, 1'b0, 32'h50, 1'b1, 1'b0);
    drive(32'h60, 32'h90, 1'b1, 1'b0, 32'h90, 1'b1, 1'b1);
    chk("mid_redirect_valid", bus.redirect_valid, 1);
    chk("mid_redirect_pc",    bus.redirect_pc,    32'h90);
    chk("mid_upd_pc",         bus.upd_pc,         32'h10);
    rstn = 1'b0;
    sb.delete();
    exp_br = 0; exp_mp = 0;
    #1;
    chk("arst_redirect_valid", bus.redirect_valid, 0);
    chk("arst_flush",          bus.flush,          0);
    chk("arst_upd_valid",      bus.upd_valid,      0);
    chk("arst_upd_pc",         bus.upd_pc,         0);
    chk_perf("arst");
    step();
    chk("arst_upd_valid_next", bus.upd_valid, 0);
    chk("arst_flush_next",     bus.flush,     0);
    rstn = 1'b1;
    bus.upd_ready = 1'b1;
    step();

    // Target mispredict, counted from reset
    drive(32'h2F0, 32'h300, 1'b1, 1'b1, 32'h380, 1'b1, 1'b1);
    chk("tgt_redirect_valid", bus.redirect_valid, 1);
    chk("tgt_redirect_pc",    bus.redirect_pc,    32'h300);
    chk("tgt_flush",          bus.flush,          1);
    chk_perf("tgt");
    step();
    chk("tgt_flush_2",        bus.flush,          1);
    step();
    chk("tgt_flush_end",      bus.flush,          0);

    // Correct prediction
    drive(32'h100, 32'h140, 1'b1, 1'b1, 32'h140, 1'b1, 1'b0);
    chk("ok_redirect_valid", bus.redirect_valid, 0);
    chk("ok_flush",          bus.flush,          0);
    chk("ok_upd_valid",      bus.upd_valid,      1);
    chk("ok_upd_pc",         bus.upd_pc,         32'h100);
    chk("ok_upd_target",     bus.upd_target,     32'h140);
    chk("ok_upd_taken",      bus.upd_taken,      1);

    // Direction mispredict; branches during flush are wrong-path
    drive(32'h200, 32'h260, 1'b0, 1'b1, 32'h260, 1'b1, 1'b1);
    chk("dir_redirect_valid", bus.redirect_valid, 1);
    chk("dir_redirect_pc",    bus.redirect_pc,    32'h204);
    chk("dir_flush_n1",       bus.flush,          1);
    drive(32'h500, 32'h540, 1'b1, 1'b0, 32'h540, 1'b0, 1'b0);
    chk("dir_redirect_pulse", bus.redirect_valid, 0);
    chk("dir_flush_n2",       bus.flush,          1);
    drive(32'h600, 32'h640, 1'b1, 1'b0, 32'h640, 1'b0, 1'b0);
    chk("dir_flush_n3",       bus.flush,          0);
    chk("dir_no_redirect",    bus.redirect_valid, 0);

    // PC wrap on not-taken correction
    drive(32'hFFFF_FFFC, 32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
    chk("wrap_redirect_valid", bus.redirect_valid, 1);
    chk("wrap_redirect_pc",    bus.redirect_pc,    32'h0);
    repeat (3) step();
    chk("wrap_flush_end", bus.flush, 0);

    // Fill to full with the predictor stalled
    bus.upd_ready = 1'b0;
    for (int i = 0; i < QD; i++)
      drive(32'h1000 + 32'(i * 16), 32'h1800 + 32'(i * 16), 1'b1, 1'b1,
            32'h1800 + 32'(i * 16), 1'b1, 1'b0);
    chk("full_ex_stall", bus.ex_stall, 1);
    chk("full_head_pc",  bus.upd_pc,   32'h1000);

    // Held branch with a pop while full is not pushed; it lands a cycle later
    bus.ex_valid = 1'b1; bus.ex_pc = 32'h2000; bus.ex_target = 32'h2040;
    bus.ex_taken = 1'b0; bus.ex_pred_taken = 1'b0; bus.ex_pred_target = 32'h2040;
    exp_entry = '{pc: 32'h2000, target: 32'h2040, taken: 1'b0};
    exp_acc = 1'b0;
    bus.upd_ready = 1'b1;
    step();
    chk("full_stall_after_pop", bus.ex_stall, 0);
    chk("full_head_after_pop",  bus.upd_pc,   32'h1010);
    bus.upd_ready = 1'b0;
    exp_acc = 1'b1;
    exp_br++;
    step();
    chk("full_stall_refill", bus.ex_stall, 1);
    bus.ex_valid = 1'b0;
    exp_acc = 1'b0;
    bus.upd_ready = 1'b1;
    repeat (6) step();
    chk("drain_upd_valid", bus.upd_valid, 0);
    chk("drain_ex_stall",  bus.ex_stall,  0);
    chk("drain_sb_empty",  32'(sb.size()), 0);
    chk_perf("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
